// File: rtl/alu_pkg.sv
// Shared definitions for the lab 6-bit ALU and the multiply/divide sequencer:
// ALU operation codes and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu6_muldiv_seq_alu.sv
// Combinational lab ALU: AND/OR/NOR/ADD/SUB with carry-in and carry-out.
// SUB is a + ~b + cin, so cin=1 gives a true subtract and cout=1 means no borrow.
module alu6_muldiv_seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0] sum;

    // Operation select; carry-out is only meaningful for ADD and SUB
    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        case (alu_op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
            end
            ALU_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu6_muldiv_seq.sv
// Multi-cycle multiply (shift-add) / divide (restoring) sequencer that drives
// an external combinational ALU, one add or subtract per cycle.
module alu6_muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             op_q;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] lo_nx;

    // Partial remainder shifted left by one, pulling in the next dividend bit
    assign shifted = {acc[WIDTH-2:0], lo[WIDTH-1]};

    // ALU operand drive; idle values whenever not iterating
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALU_ADD;
        alu_cin = 1'b0;
        if (state == RUN) begin
            if (!op_q) begin
                alu_a = acc;
                alu_b = lo[0] ? m : '0;
            end else begin
                alu_a   = shifted;
                alu_b   = m;
                alu_op  = ALU_SUB;
                alu_cin = 1'b1;
            end
        end
    end

    // Next acc/lo from the ALU response; kept apart from the drive block so the
    // external ALU path does not look like a combinational loop
    always_comb begin
        acc_nx = acc;
        lo_nx  = lo;
        if (!op_q) begin
            // {cout,result,lo} >> 1 written out per register
            acc_nx = {alu_cout, alu_result[WIDTH-1:1]};
            lo_nx  = {alu_result[0], lo[WIDTH-1:1]};
        end else if (acc[WIDTH-1] || alu_cout) begin
            // Shifted remainder bit 6 set means it exceeds any 6-bit divisor
            acc_nx = alu_result;
            lo_nx  = {lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = shifted;
            lo_nx  = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            m      <= '0;
            op_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        div0 <= 1'b0;
                        acc  <= '0;
                        busy <= 1'b1;
                        if (op) begin
                            lo <= opa;
                            m  <= opb;
                            if (opb == '0) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                div0   <= 1'b1;
                                res_lo <= '1;
                                res_hi <= opa;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            lo    <= opb;
                            m     <= opa;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        res_hi <= acc_nx;
                        res_lo <= lo_nx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu6_muldiv_seq.sv
// Scoreboard bench: sequencer plus lab ALU, directed and random mul/div
// operations compared against plain integer arithmetic.
module tb_alu6_muldiv_seq;
    import alu_pkg::*;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy, done, div0;
    logic [W-1:0] res_hi, res_lo;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_op;
    logic         alu_cin, alu_cout;

    typedef struct {
        int hi;
        int lo;
        int dz;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    alu6_muldiv_seq #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .div0(div0), .res_hi(res_hi), .res_lo(res_lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    alu6_muldiv_seq_alu #(.WIDTH(W)) u_alu (
        .a(alu_a), .b(alu_b), .alu_op(alu_op), .cin(alu_cin),
        .result(alu_result), .cout(alu_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: plain integer multiply/divide
    function automatic exp_t model(input logic o, input int a, input int b, input int now);
        exp_t e;
        int   p;
        if (!o) begin
            p    = a * b;
            e.hi = p / 64;
            e.lo = p % 64;
            e.dz = 0;
        end else if (b == 0) begin
            e.hi = a;
            e.lo = 63;
            e.dz = 1;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
            e.dz = 0;
        end
        e.due = now + 1 + ((o && b == 0) ? 0 : W);
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        exp_q.push_back(model(o, int'(a), int'(b), cyc));
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Assert start during the done cycle; it must not be accepted
    task automatic poke_in_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 1, 0);
        start = 1'b1;
        op    = 1'($urandom);
        opa   = W'($urandom);
        opb   = W'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) chk("done_width", 2, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_hi", int'(res_hi), e.hi);
                    chk("res_lo", int'(res_lo), e.lo);
                    chk("div0", int'(div0), e.dz);
                    chk("latency", cyc, e.due);
                    chk("busy_in_done", int'(busy), 1);
                end
            end
            prev_done = done;
        end
    end

    task automatic chk_reset_vals();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div0", int'(div0), 0);
        chk("rst_res_hi", int'(res_hi), 0);
        chk("rst_res_lo", int'(res_lo), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_op), int'(ALU_ADD));
        chk("rst_alu_cin", int'(alu_cin), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic o;
        logic [W-1:0] a, b;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 6'd63, 6'd63);
        issue(1'b0, 6'd5, 6'd0);
        issue(1'b0, 6'd0, 6'd5);
        issue(1'b0, 6'd13, 6'd11);
        issue(1'b1, 6'd45, 6'd7);
        issue(1'b1, 6'd63, 6'd1);
        issue(1'b1, 6'd5, 6'd9);
        issue(1'b1, 6'd63, 6'd63);
        issue(1'b1, 6'd20, 6'd0);
        issue(1'b0, 6'd2, 6'd3);

        // Start pulsed mid-run with other operands must be ignored
        issue(1'b0, 6'd37, 6'd29);
        @(negedge clk);
        chk("busy_in_run", int'(busy), 1);
        start = 1'b1; op = 1'b1; opa = 6'd9; opb = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_run2", int'(busy), 1);
        poke_in_done();

        // Reset at iteration 3: abort, no done, clean restart afterwards
        wait_idle();
        start = 1'b1; op = 1'b0; opa = 6'd63; opb = 6'd63;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", exp_q.size(), 0);
        issue(1'b1, 6'd45, 6'd7);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            o = 1'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(o, a, b);
            if ($urandom_range(0, 3) == 0) poke_in_done();
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu6_muldiv_seq.md
Name: alu6_muldiv_seq

Overview:
- Multi-cycle sequencer that drives one external combinational 6-bit ALU.
- Performs unsigned 6x6 multiply (shift-add) or 6/6 divide (restoring) by issuing one ALU add/sub per cycle and capturing result/cout.
- Sits beside the 6-bit ALU in the lab datapath; owns the ALU's a/b/ALUop/cin inputs while busy.
- Handshake: start/busy/done.

Parameters:
- WIDTH, 6, operand width; must match the ALU width.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide; sampled with start
- opa  input  WIDTH  multiplicand / dividend
- opb  input  WIDTH  multiplier / divisor
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- div0  output  1  divide-by-zero flag, valid with done, held until next start
- res_hi  output  WIDTH  product[11:6] or remainder
- res_lo  output  WIDTH  product[5:0] or quotient
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_op  output  4  to ALU ALUop
- alu_cin  output  1  to ALU cin
- alu_result  input  WIDTH  from ALU result
- alu_cout  input  1  from ALU cout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, div0 = 0; res_hi, res_lo = 0; counter = 0; alu_op = ALU_ADD; alu_a, alu_b, alu_cin = 0.
- Registers: acc (WIDTH), lo (WIDTH), m (WIDTH, latched opb/opa operand), cnt (CNT_W), op_q.
- IDLE:
  - start=1: latch op and operands, cnt=0, div0=0, go RUN.
  - Multiply: acc=0, lo=opb, m=opa.
  - Divide: acc=0, lo=opa, m=opb.
  - Divide with opb==0: go DONE directly; res_lo=all ones, res_hi=opa, div0=1.
- RUN, multiply, one iteration per cycle:
  - alu_a=acc, alu_b = lo[0] ? m : 0, alu_op=ALU_ADD, alu_cin=0.
  - Edge: {acc,lo} <= {alu_cout, alu_result, lo} >> 1.
- RUN, divide, one iteration per cycle:
  - shifted = {acc[WIDTH-2:0], lo[WIDTH-1]}; r_hi = acc[WIDTH-1].
  - alu_a=shifted, alu_b=m, alu_op=ALU_SUB, alu_cin=1.
  - If r_hi | alu_cout: acc<=alu_result, lo<={lo[WIDTH-2:0],1}.
  - Else: acc<=shifted, lo<={lo[WIDTH-2:0],0}.
- RUN exit: cnt increments each cycle; when cnt==WIDTH-1 the final iteration commits and state goes DONE.
- DONE: done=1 for exactly one cycle; res_hi=acc, res_lo=lo (or div0 values); next state IDLE.
- Latency: start sampled at edge N; done high in cycle N+WIDTH+1 (7 cycles for WIDTH=6). Divide-by-zero: done in cycle N+1.
- res_hi/res_lo/div0 hold after DONE until the next accepted start; they update only on entering DONE.
- start while busy: ignored, no queueing.
- start in the DONE cycle: ignored; must be re-asserted in IDLE.
- Outside RUN: alu_a=0, alu_b=0, alu_cin=0, alu_op=ALU_ADD.
- Reset mid-operation: abort immediately to reset values; no done pulse.
- Multiply: 6x6 into 12 bits never overflows; cout carries into acc msb via the shift.
- Divide: quotient ≤ opa; remainder < opb.

Decomposition:
- Shared package alu_pkg: ALUop constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_NOR=4'b1100; state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- No sub-module inside the sequencer.
- Bench top instantiates the sequencer plus the existing 6-bit ALU, with cin and cout wired to alu_cin and alu_cout.

Test Plan:
- Mul 63x63 (op=0, opa=6'h3F, opb=6'h3F) -> done in 7th cycle after start; {res_hi,res_lo}=12'hF81; div0=0.
- Mul 5x0 and 0x5 -> product 0; 13x11 -> 143 = 12'h08F.
- Div 45/7 -> res_lo=6, res_hi=3. Div 63/1 -> res_lo=63, res_hi=0. Div 5/9 -> res_lo=0, res_hi=5. Div 63/63 -> res_lo=1, res_hi=0.
- Div 20/0 -> done one cycle after start; div0=1, res_lo=6'h3F, res_hi=20; next mul 2x3 clears div0 and gives 6.
- start pulsed during RUN with different operands -> ignored; original result delivered; busy high RUN through DONE.
- rst_n low for one cycle at iteration 3 -> all outputs return to reset values, no done pulse; a following start runs cleanly.
